// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
// Optional feature macro used by this block: TICKGEN_SYNC_EN.
package tick_gen_pkg;

  localparam int unsigned TG_CNT_W   = 32;
  localparam int unsigned TG_DEF_DIV = 50000000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic mode_t to_mode(input logic oneshot);
    return oneshot ? MODE_ONESHOT : MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Divisor/mode write bus for tick_gen_multi.
interface tick_gen_multi_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 32
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_oneshot;

  modport master (output wr_en, output wr_ch, output wr_div, output wr_oneshot);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div, input  wr_oneshot);
endinterface

// File: rtl/tick_gen_channel.sv
// One tick channel: shadow/working divisor+mode, up-counter and IDLE/RUN FSM.
// With TICKGEN_SYNC_EN defined, a sync input realigns a running channel.
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = TG_CNT_W,
  parameter int unsigned DEF_DIV = TG_DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_oneshot,
`ifdef TICKGEN_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             active
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sh_div;
  mode_t            sh_mode;
  logic [CNT_W-1:0] wk_div;
  mode_t            wk_mode;
  logic [CNT_W-1:0] ld_div;
  mode_t            ld_mode;
  logic             realign;
  logic             terminal;

  // Reload value: a same-cycle write bypasses the shadow; divisor 0 acts as 1.
  always_comb begin
    ld_div  = wr_hit ? wr_div : sh_div;
    ld_mode = wr_hit ? to_mode(wr_oneshot) : sh_mode;
    if (ld_div == '0) ld_div = CNT_W'(1);
    realign = start;
`ifdef TICKGEN_SYNC_EN
    realign = start | sync;
`endif
    terminal = (cnt == wk_div - CNT_W'(1));
  end

  // Shadow register: written by the bus, never touches a period in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_div  <= CNT_W'(DEF_DIV);
      sh_mode <= MODE_PERIODIC;
    end else if (wr_hit) begin
      sh_div  <= wr_div;
      sh_mode <= to_mode(wr_oneshot);
    end
  end

  // Channel FSM with counter, working register and registered tick/active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wk_div  <= CNT_W'(DEF_DIV);
      wk_mode <= MODE_PERIODIC;
      tick    <= 1'b0;
      active  <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state   <= ST_RUN;
            cnt     <= '0;
            wk_div  <= ld_div;
            wk_mode <= ld_mode;
            active  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            active <= 1'b0;
          end else if (realign) begin
            cnt     <= '0;
            wk_div  <= ld_div;
            wk_mode <= ld_mode;
          end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
            if (wk_mode == MODE_ONESHOT) begin
              state  <= ST_IDLE;
              active <= 1'b0;
            end else begin
              wk_div  <= ld_div;
              wk_mode <= ld_mode;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator (N_CH independent channels).
// Optional global phase realign input is enabled by defining TICKGEN_SYNC_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned CNT_W   = TG_CNT_W,
  parameter int unsigned DEF_DIV = TG_DEF_DIV
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] start,
  input  logic [N_CH-1:0] stop,
  tick_gen_multi_if.slave wr,
`ifdef TICKGEN_SYNC_EN
  input  logic            sync,
`endif
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] active
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] wr_hit;

  // Decode the write channel; selects at or beyond N_CH match no channel.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr.wr_en && (wr.wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_gen_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .stop       (stop[g]),
      .wr_hit     (wr_hit[g]),
      .wr_div     (wr.wr_div),
      .wr_oneshot (wr.wr_oneshot),
`ifdef TICKGEN_SYNC_EN
      .sync       (sync),
`endif
      .tick       (tick[g]),
      .active     (active[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: countdown reference model plus directed checks.
module tb_tick_gen_multi;

  logic       clk;
  logic       reset;
  logic [2:0] start;
  logic [2:0] stop;
  logic [2:0] tick;
  logic [2:0] active;
`ifdef TICKGEN_SYNC_EN
  logic       sync;
`endif

  tick_gen_multi_if #(.CH_W(2), .CNT_W(32)) wr_if ();

  tick_gen_multi #(
    .N_CH    (3),
    .CNT_W   (32),
    .DEF_DIV (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .wr     (wr_if),
`ifdef TICKGEN_SYNC_EN
    .sync   (sync),
`endif
    .tick   (tick),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each running channel counts down the cycles left to its next tick.
  int         m_sh_div [3];
  bit         m_sh_os  [3];
  bit         m_run    [3];
  bit         m_os     [3];
  int         m_rem    [3];
  logic [2:0] m_tick;
  logic [2:0] m_act;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        m_sh_div[c] = 4;
        m_sh_os[c]  = 1'b0;
        m_run[c]    = 1'b0;
      end
      m_tick = '0;
      m_act  = '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        int d;
        bit re;
        if (wr_if.wr_en && int'(wr_if.wr_ch) == c) begin
          m_sh_div[c] = int'(wr_if.wr_div);
          m_sh_os[c]  = wr_if.wr_oneshot;
        end
        d  = (m_sh_div[c] == 0) ? 1 : m_sh_div[c];
        re = start[c];
`ifdef TICKGEN_SYNC_EN
        if (sync && m_run[c]) re = 1'b1;
`endif
        m_tick[c] = 1'b0;
        if (stop[c]) begin
          m_run[c] = 1'b0;
          m_act[c] = 1'b0;
        end else if (re) begin
          m_run[c] = 1'b1;
          m_act[c] = 1'b1;
          m_rem[c] = d;
          m_os[c]  = m_sh_os[c];
        end else if (m_run[c]) begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_tick[c] = 1'b1;
            if (m_os[c]) begin
              m_run[c] = 1'b0;
              m_act[c] = 1'b0;
            end else begin
              m_rem[c] = d;
              m_os[c]  = m_sh_os[c];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tick_vs_model", int'(tick), int'(m_tick));
      chk("active_vs_model", int'(active), int'(m_act));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int ch, input int d, input bit os);
    wr_if.wr_en      = 1'b1;
    wr_if.wr_ch      = 2'(ch);
    wr_if.wr_div     = 32'(d);
    wr_if.wr_oneshot = os;
    step();
    wr_if.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    start = m;
    step();
    start = '0;
  endtask

  int n;

  initial begin
    reset = 1'b1;
    start = '0;
    stop  = '0;
    wr_if.wr_en      = 1'b0;
    wr_if.wr_ch      = '0;
    wr_if.wr_div     = '0;
    wr_if.wr_oneshot = 1'b0;
`ifdef TICKGEN_SYNC_EN
    sync = 1'b0;
`endif
    step();
    step();
    chk("reset_tick", int'(tick), 0);
    chk("reset_active", int'(active), 0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    step();

    // ch0 periodic at default divisor 4
    pulse_start(3'b001);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t1_wait", int'(tick[0]), 0);
    end
    step();
    chk("t1_first_tick", int'(tick[0]), 1);
    chk("t1_model_first_tick", int'(m_tick[0]), 1);
    chk("t1_active", int'(active[0]), 1);
    repeat (3) step();
    step();
    chk("t1_second_tick", int'(tick[0]), 1);

    // ch1 one-shot at divisor 3
    wr(1, 3, 1'b1);
    pulse_start(3'b010);
    step();
    step();
    chk("t2_wait", int'(tick[1]), 0);
    chk("t2_active", int'(active[1]), 1);
    step();
    chk("t2_tick", int'(tick[1]), 1);
    chk("t2_active_fall", int'(active[1]), 0);
    n = 0;
    repeat (10) begin
      step();
      n += int'(tick[1]);
    end
    chk("t2_no_more_ticks", n, 0);

    // ch2 divisor 0 behaves as 1
    wr(2, 0, 1'b0);
    pulse_start(3'b100);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t3_every_cycle", int'(tick[2]), 1);
    end

    // stop everything, then write during a running period
    stop = 3'b111;
    step();
    stop = '0;
    chk("t4_all_idle", int'(active), 0);
    wr(0, 5, 1'b0);
    pulse_start(3'b001);
    step();
    wr(0, 2, 1'b0);
    step();
    step();
    chk("t4_no_early_tick", int'(tick[0]), 0);
    step();
    chk("t4_old_period", int'(tick[0]), 1);
    step();
    chk("t4_gap", int'(tick[0]), 0);
    step();
    chk("t4_new_period", int'(tick[0]), 1);
    start = 3'b001;
    stop  = 3'b001;
    step();
    start = '0;
    stop  = '0;
    chk("t4_stop_wins", int'(active[0]), 0);
    n = 0;
    repeat (6) begin
      step();
      n += int'(tick[0]);
    end
    chk("t4_idle_no_ticks", n, 0);

    // reset mid-count
    wr(0, 4, 1'b0);
    pulse_start(3'b001);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("t5_reset_tick", int'(tick), 0);
    chk("t5_reset_active", int'(active), 0);
    step();
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      step();
      n += int'(tick[0]) + int'(tick[1]) + int'(tick[2]);
    end
    chk("t5_no_tick_after_release", n, 0);
    chk("t5_idle_after_release", int'(active), 0);

    // out-of-range write ignored; simultaneous ticks; restart in RUN
    wr(3, 1, 1'b0);
    pulse_start(3'b011);
    repeat (3) step();
    chk("t6_ignored_write", int'(tick[1:0]), 0);
    step();
    chk("t6_both_tick", int'(tick[1:0]), 3);
    pulse_start(3'b001);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t6_restart_wait", int'(tick[0]), 0);
    end
    step();
    chk("t6_restart_tick", int'(tick[0]), 1);

`ifdef TICKGEN_SYNC_EN
    // global realign of two out-of-phase channels
    stop = 3'b111;
    step();
    stop = '0;
    wr(1, 6, 1'b0);
    pulse_start(3'b001);
    step();
    pulse_start(3'b010);
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t7_sync_ch0", int'(tick[0]), (k == 4) ? 1 : 0);
      chk("t7_sync_ch1", int'(tick[1]), (k == 6) ? 1 : 0);
    end
`endif

    step();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel programmable clock-enable generator; the parametrised successor to the fixed 1 Hz enable used for vend timing. Each of N_CH channels divides clk by a runtime-loadable divisor and emits single-cycle `tick` pulses, either periodically or once. It sits beside the vending FSM and supplies vend-delay, display-refresh and debounce enables from one block.

## Interface
- N_CH, 3, number of independent channels (1..8)
- CNT_W, 32, counter/divisor width
- DEF_DIV, 50000000, divisor loaded into every channel at reset (1 Hz at 50 MHz)
- CH_W, $clog2(N_CH) with minimum 1, channel-select width (derived)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  N_CH  per-channel start/restart request
- stop  in  N_CH  per-channel stop request
- wr_en  in  1  divisor/mode write strobe
- wr_ch  in  CH_W  channel selected by the write
- wr_div  in  CNT_W  new divisor
- wr_oneshot  in  1  new mode: 1 = one-shot, 0 = periodic
- tick  out  N_CH  single-cycle enable pulse, registered
- active  out  N_CH  channel is counting, registered
- sync  in  1  global phase realign (present only with TICKGEN_SYNC_EN)

## Operation
- Per channel, two states: IDLE and RUN.
- Reset: all counters 0, tick = 0, active = 0, state IDLE, shadow divisor = DEF_DIV, shadow mode = periodic.
- Each channel holds a shadow register (div, oneshot) and a working register (div, oneshot).
- A write with wr_en = 1 updates only the shadow of channel wr_ch. A wr_ch ≥ N_CH is ignored.
- The working register copies the shadow on start and on every terminal count, so a write never disturbs a period in progress.
- A divisor of 0 is treated as 1.
- IDLE -> RUN on start: counter ← 0, working ← shadow, active ← 1.
- In RUN, the counter increments each cycle. When counter == div−1:
  - counter ← 0 and tick ← 1.
  - Periodic mode: stays in RUN and reloads the working register.
  - One-shot mode: goes to IDLE with active ← 0.
- start while in RUN restarts the channel: counter ← 0, working ← shadow, and no tick that cycle.
- stop in RUN -> IDLE: counter ← 0, active ← 0, and the pending tick is suppressed. stop in IDLE has no effect.
- If start and stop arrive in the same cycle, stop wins.
- A write and a start to the same channel in the same cycle: the start uses the new write data (shadow bypass).
- A write coinciding with a terminal count: the reload uses the new write data.
- Channels are fully independent. Several ticks may assert in the same cycle.

## Timing
- start sampled at edge E0 -> first tick high during the cycle after edge E0+div, i.e. div cycles of latency.
- Periodic mode: tick period is exactly div cycles. div = 1 gives tick high every cycle from E0+1 onward.
- One-shot mode: one tick, and active falls at the same edge tick rises.
- tick and active change only on clk edges. Reset clears them asynchronously.
- Reset asserted mid-count: the count is abandoned and no tick is produced after reset releases until a new start.
- Counter never wraps past div−1. CNT_W must hold DEF_DIV−1.

## Configuration
- Macro: TICKGEN_SYNC_EN.
- Defined:
  - The `sync` port exists.
  - When sync = 1, every channel in RUN sets counter ← 0, reloads its working register, and suppresses tick that cycle.
  - IDLE channels are unaffected.
  - sync takes priority below stop and equal to start.
- Undefined: the port is absent and no realign logic is generated.

## Structure
- Shared package tick_gen_pkg holds:
  - mode enum: MODE_PERIODIC, MODE_ONESHOT.
  - state enum: ST_IDLE, ST_RUN.
  - default CNT_W and DEF_DIV constants.
- Sub-module tick_gen_channel implements one channel: shadow/working registers, counter and FSM.
- The top-level instantiates N_CH channels via generate and decodes wr_ch to per-channel write strobes.

## Test plan
- Reset, then start[0] with DEF_DIV overridden to 4 -> tick[0] pulses 4 cycles after start and every 4 cycles after that; active[0] stays 1.
- Write ch1 div = 3, oneshot = 1, then start[1] -> one tick 3 cycles later, active[1] falls at that edge, no further ticks.
- Write div = 0 to ch2, then start -> tick[2] high every cycle.
- ch0 running at div 5, write div = 2 at count 1 -> the current period stays 5 cycles, later periods are 2; a same-cycle start and stop on ch0 -> channel goes IDLE.
- Reset asserted at count 2 of div 4 -> tick = 0, active = 0 immediately; no tick after release without a new start.
- With TICKGEN_SYNC_EN: ch0 at div 4 and ch1 at div 6 running out of phase, pulse sync -> both counters zero, and the next ticks fall 4 and 6 cycles later.
